// File: rtl/cpu_param.sv
// cpu_param: parameterised single-issue CPU core with a two-state
// memory handshake.
//
// Ports:
//   CLK          clock; all state changes on the rising edge
//   RESET        synchronous, active-high reset
//   INSTRUCTION  32-bit instruction at PC:
//                [31:24] opcode, [23:16] RD/OFFSET, [15:8] RT, [7:0] RS/IMM
//   READDATA     data-memory read data (DATA_W)
//   BUSYWAIT     data memory busy
//   PC           instruction address (32)
//   READ/WRITE   data-memory request strobes
//   ADDRESS      data-memory address (ADDR_W), low bits of the ALU result
//   WRITEDATA    store data, reg[RT] (DATA_W)
//   ILLEGAL      undefined opcode seen in RUN
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | execute one instruction per cycle, or issue a memory request
// MEMWAIT | hold PC until the memory drops BUSYWAIT, then retire the op
module cpu_param #(
  parameter int DATA_W = 8,
  parameter int REG_N  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic [DATA_W-1:0] READDATA,
  input  logic              BUSYWAIT,
  output logic [31:0]       PC,
  output logic              READ,
  output logic              WRITE,
  output logic [ADDR_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  output logic              ILLEGAL
);

  localparam int RW = $clog2(REG_N);
  localparam logic [7:0] DW8 = 8'(DATA_W);

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;
  localparam logic [7:0] OP_J     = 8'd6;
  localparam logic [7:0] OP_BEQ   = 8'd7;
  localparam logic [7:0] OP_LWD   = 8'd8;
  localparam logic [7:0] OP_LWI   = 8'd9;
  localparam logic [7:0] OP_SWD   = 8'd10;
  localparam logic [7:0] OP_SWI   = 8'd11;
  localparam logic [7:0] OP_BNE   = 8'd12;
  localparam logic [7:0] OP_SLL   = 8'd13;
  localparam logic [7:0] OP_SRL   = 8'd14;
  localparam logic [7:0] OP_SRA   = 8'd15;
  localparam logic [7:0] OP_ROR   = 8'd16;

  typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

  state_t state;

  logic [DATA_W-1:0] regs [REG_N];

  logic [7:0]        opcode, f_rd, f_rt, f_imm;
  logic [RW-1:0]     rd_idx, rt_idx, rs_idx;
  logic [DATA_W-1:0] rt_val, rs_val, imm_z, diff;
  logic [DATA_W-1:0] sll_res, srl_res, sra_res, ror_res;
  logic [7:0]        rot_amt;
  logic              zero;
  logic [31:0]       pc_plus4, pc_branch;

  logic [DATA_W-1:0] alu;
  logic              reg_we, is_mem, is_load, br_taken, illegal_op;

  // Request captured when a memory op leaves RUN; drives the bus in MEMWAIT
  // so ADDRESS/WRITEDATA cannot move even if the fetch port does.
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [RW-1:0]     mem_rd_q;
  logic              mem_load_q;

  logic              unused_bits;

  assign opcode = INSTRUCTION[31:24];
  assign f_rd   = INSTRUCTION[23:16];
  assign f_rt   = INSTRUCTION[15:8];
  assign f_imm  = INSTRUCTION[7:0];

  assign rd_idx = f_rd[RW-1:0];
  assign rt_idx = f_rt[RW-1:0];
  assign rs_idx = f_imm[RW-1:0];

  assign rt_val = regs[rt_idx];
  assign rs_val = regs[rs_idx];
  assign imm_z  = DATA_W'(f_imm);
  assign diff   = rt_val - rs_val;
  assign zero   = (diff == '0);

  // Shift amounts at or beyond the register width saturate; rotate wraps.
  assign sll_res = (f_imm >= DW8) ? '0 : (rt_val << f_imm);
  assign srl_res = (f_imm >= DW8) ? '0 : (rt_val >> f_imm);
  assign sra_res = (f_imm >= DW8) ? {DATA_W{rt_val[DATA_W-1]}}
                                  : DATA_W'($signed(rt_val) >>> f_imm);
  assign rot_amt = f_imm % DW8;
  // A zero rotate shifts the left term out entirely, leaving rt_val intact.
  assign ror_res = (rt_val >> rot_amt) | (rt_val << (DW8 - rot_amt));

  assign pc_plus4  = PC + 32'd4;
  assign pc_branch = pc_plus4 + {{22{f_rd[7]}}, f_rd, 2'b00};

  always_comb begin
    alu        = '0;
    reg_we     = 1'b0;
    is_mem     = 1'b0;
    is_load    = 1'b0;
    br_taken   = 1'b0;
    illegal_op = 1'b0;
    case (opcode)
      OP_LOADI: begin alu = imm_z;           reg_we = 1'b1; end
      OP_MOV:   begin alu = rs_val;          reg_we = 1'b1; end
      OP_ADD:   begin alu = rt_val + rs_val; reg_we = 1'b1; end
      OP_SUB:   begin alu = diff;            reg_we = 1'b1; end
      OP_AND:   begin alu = rt_val & rs_val; reg_we = 1'b1; end
      OP_OR:    begin alu = rt_val | rs_val; reg_we = 1'b1; end
      OP_J:     br_taken = 1'b1;
      OP_BEQ:   br_taken = zero;
      OP_BNE:   br_taken = ~zero;
      OP_LWD:   begin alu = rs_val; is_mem = 1'b1; is_load = 1'b1; end
      OP_LWI:   begin alu = imm_z;  is_mem = 1'b1; is_load = 1'b1; end
      OP_SWD:   begin alu = rs_val; is_mem = 1'b1; end
      OP_SWI:   begin alu = imm_z;  is_mem = 1'b1; end
      OP_SLL:   begin alu = sll_res; reg_we = 1'b1; end
      OP_SRL:   begin alu = srl_res; reg_we = 1'b1; end
      OP_SRA:   begin alu = sra_res; reg_we = 1'b1; end
      OP_ROR:   begin alu = ror_res; reg_we = 1'b1; end
      default:  illegal_op = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= RUN;
      PC          <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= '0;
      mem_load_q  <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else if (state == RUN) begin
      if (!BUSYWAIT) begin
        if (is_mem) begin
          state       <= MEMWAIT;
          mem_addr_q  <= alu[ADDR_W-1:0];
          mem_wdata_q <= rt_val;
          mem_rd_q    <= rd_idx;
          mem_load_q  <= is_load;
        end else begin
          PC <= br_taken ? pc_branch : pc_plus4;
          if (reg_we) regs[rd_idx] <= alu;
        end
      end
    end else begin
      if (!BUSYWAIT) begin
        if (mem_load_q) regs[mem_rd_q] <= READDATA;
        PC    <= pc_plus4;
        state <= RUN;
      end
    end
  end

  assign ADDRESS   = (state == MEMWAIT) ? mem_addr_q  : alu[ADDR_W-1:0];
  assign WRITEDATA = (state == MEMWAIT) ? mem_wdata_q : rt_val;

  // In MEMWAIT the strobe follows BUSYWAIT so it falls on the retiring cycle.
  assign READ  = ~RESET & ((state == RUN) ? (is_mem & is_load)
                                          : (mem_load_q & BUSYWAIT));
  assign WRITE = ~RESET & ((state == RUN) ? (is_mem & ~is_load)
                                          : (~mem_load_q & BUSYWAIT));
  assign ILLEGAL = ~RESET & (state == RUN) & illegal_op;

  assign unused_bits = ^{f_rt, alu};

endmodule
